// File: rtl/tag_lookup_pkg.sv
// tag_lookup_pkg: default cache geometry shared by the tag-check stage and its valid array.
package tag_lookup_pkg;
   localparam int ADDR_BITS_DEF   = 32;
   localparam int OFFSET_BITS_DEF = 6;
   localparam int SET_BITS_DEF    = 2;
   localparam int TAG_BITS_DEF    = ADDR_BITS_DEF - OFFSET_BITS_DEF - SET_BITS_DEF;
endpackage

// File: rtl/tag_lookup_valid_array.sv
// tag_valid_array: per-set valid flops; a global clear beats a same-cycle set.
module tag_valid_array
   import tag_lookup_pkg::*;
#(
   parameter int SET_BITS = SET_BITS_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_set,
   input  logic [SET_BITS-1:0] i_set_idx,
   input  logic                i_clr,
   input  logic [SET_BITS-1:0] i_rd_idx,
   output logic                o_rd_valid
);
   logic [(1<<SET_BITS)-1:0] r_valid;
   always_ff @(posedge clk or posedge rst)
      if (rst) r_valid <= '0;
      else if (i_clr) r_valid <= '0;
      else if (i_set) r_valid[i_set_idx] <= 1'b1;
   assign o_rd_valid = r_valid[i_rd_idx];
endmodule

// File: rtl/tag_lookup.sv
// tag_lookup: direct-mapped tag check in front of the tag SRAM; refills win over lookups in IDLE.
module tag_lookup
   import tag_lookup_pkg::*;
#(
   parameter int ADDR_BITS      = ADDR_BITS_DEF,
   parameter int OFFSET_BITS    = OFFSET_BITS_DEF,
   parameter int CACHE_SET_BITS = SET_BITS_DEF,
   parameter int CACHE_TAG_BITS = TAG_BITS_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_req_valid,
   output logic                      o_req_ready,
   input  logic [ADDR_BITS-1:0]      i_req_addr,
   output logic                      o_resp_valid,
   input  logic                      i_resp_ready,
   output logic                      o_resp_hit,
   output logic [CACHE_SET_BITS-1:0] o_resp_set,
   output logic [CACHE_TAG_BITS-1:0] o_resp_tag,
   input  logic                      i_fill_valid,
   output logic                      o_fill_ready,
   input  logic [ADDR_BITS-1:0]      i_fill_addr,
   input  logic                      i_inval,
   output logic                      o_tag_we,
   output logic [CACHE_SET_BITS-1:0] o_tag_addr,
   output logic [CACHE_TAG_BITS-1:0] o_tag_din,
   input  logic [CACHE_TAG_BITS-1:0] i_tag_dout
);
   localparam logic [1:0] S_IDLE = 2'd0, S_LOOKUP = 2'd1, S_RESP = 2'd2;
   logic [1:0]                r_state;
   logic [CACHE_SET_BITS-1:0] r_set;
   logic [CACHE_TAG_BITS-1:0] r_tag;
   logic                      r_hit;
   logic                      w_idle, w_fill_acc, w_req_acc, w_valid, w_hit, w_unused;
   logic [CACHE_SET_BITS-1:0] w_fill_set, w_req_set;
   logic [CACHE_TAG_BITS-1:0] w_fill_tag, w_req_tag;
   assign w_fill_set = i_fill_addr[OFFSET_BITS +: CACHE_SET_BITS];
   assign w_fill_tag = i_fill_addr[ADDR_BITS-1 -: CACHE_TAG_BITS];
   assign w_req_set  = i_req_addr[OFFSET_BITS +: CACHE_SET_BITS];
   assign w_req_tag  = i_req_addr[ADDR_BITS-1 -: CACHE_TAG_BITS];
   assign w_unused   = ^{i_req_addr[OFFSET_BITS-1:0], i_fill_addr[OFFSET_BITS-1:0]};
   // Handshakes are held off while reset is asserted, even though the state is already IDLE.
   assign w_idle       = (r_state == S_IDLE) & ~rst;
   assign o_fill_ready = w_idle;
   assign o_req_ready  = w_idle & ~i_fill_valid;
   assign w_fill_acc   = i_fill_valid & o_fill_ready;
   assign w_req_acc    = i_req_valid & o_req_ready;
   assign o_tag_we     = w_fill_acc;
   assign o_tag_addr   = w_fill_acc ? w_fill_set : w_req_acc ? w_req_set : '0;
   assign o_tag_din    = w_fill_tag;
   assign o_resp_valid = r_state == S_RESP;
   assign o_resp_hit   = r_hit;
   assign o_resp_set   = r_set;
   assign o_resp_tag   = r_tag;
   assign w_hit        = w_valid & ~i_inval & (i_tag_dout == r_tag);
   tag_valid_array #(.SET_BITS(CACHE_SET_BITS)) u_valid (
      .clk        (clk),
      .rst        (rst),
      .i_set      (w_fill_acc),
      .i_set_idx  (w_fill_set),
      .i_clr      (i_inval),
      .i_rd_idx   (r_set),
      .o_rd_valid (w_valid)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_state <= S_IDLE;
         r_set   <= '0;
         r_tag   <= '0;
         r_hit   <= 1'b0;
      end else if (w_req_acc) begin
         r_state <= S_LOOKUP;
         r_set   <= w_req_set;
         r_tag   <= w_req_tag;
      end else if (r_state == S_LOOKUP) begin
         r_state <= S_RESP;
         r_hit   <= w_hit;
      end else if (r_state == S_RESP && i_resp_ready) begin
         r_state <= S_IDLE;
      end
endmodule
